axis_pkt_source: RTL and testbench

AXIS_PKT_SOURCE -- requirements
Module: axis_pkt_source

---
 rtl/axis_pkg.sv | 41 ++++
 rtl/axis_pkt_source.sv | 152 +++++++++++++++
 tb/tb_axis_pkt_source.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream packet source.
// Contents:
//   state_e           packet FSM state encoding
//   MAX_DATA_WIDTH    widest TDATA supported by keep_mask()
//   MAX_BYTES         byte lanes at MAX_DATA_WIDTH
//   bytes_of()        byte lanes for a given TDATA width
//   last_bytes_width()  width of the last-beat byte-count field
//   keep_mask()       last-beat byte count -> TKEEP/TSTRB mask
package axis_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } state_e;

   localparam int unsigned MAX_DATA_WIDTH = 1024;
   localparam int unsigned MAX_BYTES      = MAX_DATA_WIDTH / 8;

   function automatic int unsigned bytes_of(input int unsigned data_width);
      return data_width / 8;
   endfunction

   function automatic int unsigned last_bytes_width(input int unsigned data_width);
      return $clog2(data_width / 8) + 1;
   endfunction

   // A count of 0 or one that covers every lane means a full beat; otherwise the
   // low 'last_bytes' lanes are valid. Lanes at or above 'bytes' are always 0.
   function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned last_bytes,
                                                      input int unsigned bytes);
      logic [MAX_BYTES-1:0] m;
      logic                 full;
      full = (last_bytes == 0) || (last_bytes >= bytes);
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         m[i] = full ? (i < bytes) : (i < last_bytes);
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_pkt_source.sv
// AXI4-Stream packet source. Accepts one packet command at a time and emits
// cmd_len+1 beats whose TDATA counts up from cmd_seed, with optional idle gaps
// between beats. Every output comes straight from a register.
// Ports:
//   ACLK, ARESETn     clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake
//   cmd_len           beats minus one
//   cmd_seed          TDATA of the first beat
//   cmd_last_bytes    valid bytes in the last beat (0 or >= BYTES: full beat)
//   cmd_tid/tdest     TID/TDEST for the whole packet
//   cfg_gap           idle cycles after each non-last beat, sampled at accept
//   TVALID..TUSER     AXI4-Stream master; TUSER marks start of packet
//   busy              packet in progress
//   pkt_done          one-cycle pulse after the last-beat handshake
module axis_pkt_source
   import axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DEST_WIDTH = 4,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned GAP_WIDTH  = 4,
   localparam int unsigned BYTES     = bytes_of(DATA_WIDTH),
   localparam int unsigned LB_WIDTH  = last_bytes_width(DATA_WIDTH)
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [DATA_WIDTH-1:0] cmd_seed,
   input  logic [LB_WIDTH-1:0]   cmd_last_bytes,
   input  logic [ID_WIDTH-1:0]   cmd_tid,
   input  logic [DEST_WIDTH-1:0] cmd_tdest,
   input  logic [GAP_WIDTH-1:0]  cfg_gap,
   output logic                  TVALID,
   input  logic                  TREADY,
   output logic [DATA_WIDTH-1:0] TDATA,
   output logic [BYTES-1:0]      TSTRB,
   output logic [BYTES-1:0]      TKEEP,
   output logic                  TLAST,
   output logic [ID_WIDTH-1:0]   TID,
   output logic [DEST_WIDTH-1:0] TDEST,
   output logic                  TUSER,
   output logic                  busy,
   output logic                  pkt_done
);

   state_e                state;
   logic [LEN_WIDTH-1:0]  beat_cnt;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [GAP_WIDTH-1:0]  gap_q;
   logic [GAP_WIDTH-1:0]  gap_cnt;
   logic [BYTES-1:0]      last_mask_q;

   logic [BYTES-1:0]      cmd_mask;
   logic [LEN_WIDTH-1:0]  next_beat;
   logic                  next_is_last;

   assign cmd_mask     = BYTES'(keep_mask(32'(cmd_last_bytes), BYTES));
   // Only evaluated while the current beat is not the last, so it never wraps
   // even with cmd_len at its maximum.
   assign next_beat    = beat_cnt + LEN_WIDTH'(1);
   assign next_is_last = (next_beat == len_q);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state       <= StIdle;
         cmd_ready   <= 1'b0;
         TVALID      <= 1'b0;
         TDATA       <= '0;
         TSTRB       <= '0;
         TKEEP       <= '0;
         TLAST       <= 1'b0;
         TID         <= '0;
         TDEST       <= '0;
         TUSER       <= 1'b0;
         busy        <= 1'b0;
         pkt_done    <= 1'b0;
         beat_cnt    <= '0;
         len_q       <= '0;
         gap_q       <= '0;
         gap_cnt     <= '0;
         last_mask_q <= '0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            StIdle: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               TVALID    <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  state       <= StSend;
                  cmd_ready   <= 1'b0;
                  busy        <= 1'b1;
                  TVALID      <= 1'b1;
                  TDATA       <= cmd_seed;
                  TUSER       <= 1'b1;
                  TLAST       <= (cmd_len == '0);
                  TKEEP       <= (cmd_len == '0) ? cmd_mask : '1;
                  TSTRB       <= (cmd_len == '0) ? cmd_mask : '1;
                  TID         <= cmd_tid;
                  TDEST       <= cmd_tdest;
                  len_q       <= cmd_len;
                  gap_q       <= cfg_gap;
                  last_mask_q <= cmd_mask;
                  beat_cnt    <= '0;
               end
            end
            StSend: begin
               // TVALID is always high here, so TREADY alone marks a handshake.
               if (TREADY) begin
                  if (TLAST) begin
                     state     <= StIdle;
                     TVALID    <= 1'b0;
                     TLAST     <= 1'b0;
                     TUSER     <= 1'b0;
                     busy      <= 1'b0;
                     pkt_done  <= 1'b1;
                     cmd_ready <= 1'b1;
                  end else begin
                     beat_cnt <= next_beat;
                     TDATA    <= TDATA + DATA_WIDTH'(1);
                     TUSER    <= 1'b0;
                     TLAST    <= next_is_last;
                     TKEEP    <= next_is_last ? last_mask_q : '1;
                     TSTRB    <= next_is_last ? last_mask_q : '1;
                     if (gap_q != '0) begin
                        state   <= StGap;
                        TVALID  <= 1'b0;
                        gap_cnt <= gap_q;
                     end
                  end
               end
            end
            StGap: begin
               // Beat fields were already advanced on entry; only TVALID waits.
               if (gap_cnt == GAP_WIDTH'(1)) begin
                  state  <= StSend;
                  TVALID <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GAP_WIDTH'(1);
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pkt_source.sv
module tb_axis_pkt_source;

   logic        ACLK;
   logic        ARESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_len;
   logic [31:0] cmd_seed;
   logic [2:0]  cmd_last_bytes;
   logic [3:0]  cmd_tid;
   logic [3:0]  cmd_tdest;
   logic [3:0]  cfg_gap;
   logic        TVALID;
   logic        TREADY;
   logic [31:0] TDATA;
   logic [3:0]  TSTRB;
   logic [3:0]  TKEEP;
   logic        TLAST;
   logic [3:0]  TID;
   logic [3:0]  TDEST;
   logic        TUSER;
   logic        busy;
   logic        pkt_done;

   axis_pkt_source dut (
      .ACLK           (ACLK),
      .ARESETn        (ARESETn),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_len        (cmd_len),
      .cmd_seed       (cmd_seed),
      .cmd_last_bytes (cmd_last_bytes),
      .cmd_tid        (cmd_tid),
      .cmd_tdest      (cmd_tdest),
      .cfg_gap        (cfg_gap),
      .TVALID         (TVALID),
      .TREADY         (TREADY),
      .TDATA          (TDATA),
      .TSTRB          (TSTRB),
      .TKEEP          (TKEEP),
      .TLAST          (TLAST),
      .TID            (TID),
      .TDEST          (TDEST),
      .TUSER          (TUSER),
      .busy           (busy),
      .pkt_done       (pkt_done)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int checks = 0;
   int errors = 0;

   // Per-cycle capture of one packet run
   logic        ready_pat [32];
   logic        cyc_valid [32];
   logic        cyc_user  [32];
   logic        cyc_last  [32];
   logic        cyc_done  [32];
   logic        cyc_busy  [32];
   logic        cyc_rdy   [32];
   logic [31:0] cyc_data  [32];
   logic [3:0]  cyc_keep  [32];
   logic [3:0]  cyc_strb  [32];
   logic [7:0]  cyc_id    [32];
   logic [31:0] beat_data [32];
   int          nbeats;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return {10'd0, cmd_ready, TVALID, TLAST, TUSER, TDATA, TSTRB, TKEEP, TID, TDEST,
              busy, pkt_done};
   endfunction

   task automatic set_ready_all(input logic v);
      for (int i = 0; i < 32; i++) ready_pat[i] = v;
   endtask

   // Waits (bounded) for cmd_ready, presents one command, then scrambles the
   // command inputs so a packet that re-reads them would be caught.
   task automatic send_cmd(input logic [15:0] len, input logic [31:0] seed,
                           input logic [2:0] lb, input logic [3:0] gap,
                           input logic [3:0] tid, input logic [3:0] tdest);
      int w;
      w = 0;
      while (!cmd_ready && w < 20) begin
         tick();
         w++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      cmd_len        = len;
      cmd_seed       = seed;
      cmd_last_bytes = lb;
      cfg_gap        = gap;
      cmd_tid        = tid;
      cmd_tdest      = tdest;
      cmd_valid      = 1'b1;
      tick();
      cmd_valid      = 1'b0;
      cmd_len        = 16'h0007;
      cmd_seed       = 32'hDEAD_BEEF;
      cmd_last_bytes = 3'd1;
      cfg_gap        = 4'd5;
      cmd_tid        = 4'hF;
      cmd_tdest      = 4'hE;
   endtask

   task automatic run(input int n);
      nbeats = 0;
      for (int i = 0; i < n; i++) begin
         TREADY       = ready_pat[i];
         cyc_valid[i] = TVALID;
         cyc_user[i]  = TUSER;
         cyc_last[i]  = TLAST;
         cyc_done[i]  = pkt_done;
         cyc_busy[i]  = busy;
         cyc_rdy[i]   = cmd_ready;
         cyc_data[i]  = TDATA;
         cyc_keep[i]  = TKEEP;
         cyc_strb[i]  = TSTRB;
         cyc_id[i]    = {TID, TDEST};
         if (TVALID && TREADY) begin
            beat_data[nbeats] = TDATA;
            nbeats++;
         end
         tick();
      end
      TREADY = 1'b0;
   endtask

   logic [7:0]  vpat;
   logic [31:0] exp5 [4];
   int          ndone;

   initial begin
      ARESETn        = 1'b0;
      cmd_valid      = 1'b0;
      TREADY         = 1'b0;
      cmd_len        = '0;
      cmd_seed       = '0;
      cmd_last_bytes = '0;
      cmd_tid        = '0;
      cmd_tdest      = '0;
      cfg_gap        = '0;

      // Reset state
      #3;
      check("rst_async_outs", all_outs(), 0);
      repeat (2) tick();
      check("rst_held_outs", all_outs(), 0);
      ARESETn = 1'b1;
      tick();
      check("rst_rel_ready", cmd_ready, 1);
      check("rst_rel_valid", TVALID, 0);
      check("rst_rel_busy", busy, 0);

      // 4 back-to-back beats, partial last beat
      set_ready_all(1'b1);
      send_cmd(16'd3, 32'h10, 3'd2, 4'd0, 4'h5, 4'hA);
      run(6);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1_valid%0d", k), cyc_valid[k], 1);
         check($sformatf("t1_data%0d", k), cyc_data[k], 32'h10 + 32'(k));
         check($sformatf("t1_user%0d", k), cyc_user[k], k == 0);
         check($sformatf("t1_last%0d", k), cyc_last[k], k == 3);
         check($sformatf("t1_keep%0d", k), cyc_keep[k], (k == 3) ? 4'h3 : 4'hF);
         check($sformatf("t1_strb%0d", k), cyc_strb[k], (k == 3) ? 4'h3 : 4'hF);
      end
      check("t1_id0", cyc_id[0], 8'h5A);
      check("t1_id3", cyc_id[3], 8'h5A);
      check("t1_rdy_busy", cyc_rdy[0], 0);
      check("t1_busy", cyc_busy[0], 1);
      check("t1_done_early", cyc_done[3], 0);
      check("t1_done", cyc_done[4], 1);
      check("t1_after_valid", cyc_valid[4], 0);
      check("t1_after_busy", cyc_busy[4], 0);
      check("t1_done_pulse", cyc_done[5], 0);
      check("t1_nbeats", nbeats, 4);

      // Backpressure for 3 cycles on beat 1
      set_ready_all(1'b1);
      ready_pat[1] = 1'b0;
      ready_pat[2] = 1'b0;
      ready_pat[3] = 1'b0;
      send_cmd(16'd3, 32'h10, 3'd2, 4'd0, 4'h5, 4'hA);
      run(10);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("t2_hold_data%0d", i), cyc_data[i], 32'h11);
         check($sformatf("t2_hold_valid%0d", i), cyc_valid[i], 1);
         check($sformatf("t2_hold_user%0d", i), cyc_user[i], 0);
      end
      check("t2_nbeats", nbeats, 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_beat%0d", i), beat_data[i], 32'h10 + 32'(i));
      ndone = 0;
      for (int i = 0; i < 10; i++) if (cyc_done[i]) ndone++;
      check("t2_done_cnt", ndone, 1);
      check("t2_done_cyc", cyc_done[7], 1);

      // Gap of 2 idle cycles between beats
      set_ready_all(1'b1);
      send_cmd(16'd2, 32'h40, 3'd0, 4'd2, 4'h1, 4'h2);
      run(9);
      for (int i = 0; i < 8; i++) vpat[i] = cyc_valid[i];
      check("t3_valid_pat", vpat, 8'h49);
      check("t3_nbeats", nbeats, 3);
      check("t3_beat2", beat_data[2], 32'h42);
      check("t3_last", cyc_last[6], 1);
      check("t3_done", cyc_done[7], 1);

      // Single-beat packet, last_bytes 0 = full beat
      set_ready_all(1'b1);
      send_cmd(16'd0, 32'hA5, 3'd0, 4'd0, 4'h3, 4'h3);
      run(3);
      check("t4_valid", cyc_valid[0], 1);
      check("t4_data", cyc_data[0], 32'hA5);
      check("t4_user", cyc_user[0], 1);
      check("t4_last", cyc_last[0], 1);
      check("t4_keep", cyc_keep[0], 4'hF);
      check("t4_done", cyc_done[1], 1);
      check("t4_after_valid", cyc_valid[1], 0);

      // TDATA wraps modulo 2^32
      exp5[0] = 32'hFFFF_FFFE;
      exp5[1] = 32'hFFFF_FFFF;
      exp5[2] = 32'h0000_0000;
      exp5[3] = 32'h0000_0001;
      set_ready_all(1'b1);
      send_cmd(16'd3, 32'hFFFF_FFFE, 3'd1, 4'd0, 4'h0, 4'h0);
      run(6);
      check("t5_nbeats", nbeats, 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t5_beat%0d", i), beat_data[i], exp5[i]);
      check("t5_keep_last", cyc_keep[3], 4'h1);

      // Reset in the middle of beat 2, then a fresh packet
      send_cmd(16'd5, 32'h100, 3'd0, 4'd0, 4'h2, 4'h4);
      TREADY = 1'b1;
      tick();
      tick();
      check("t6_pre_data", TDATA, 32'h102);
      check("t6_pre_valid", TVALID, 1);
      ARESETn = 1'b0;
      #1;
      check("t6_rst_async", all_outs(), 0);
      tick();
      check("t6_rst_held", all_outs(), 0);
      #1;
      ARESETn = 1'b1;
      TREADY  = 1'b0;
      tick();
      check("t6_rel_ready", cmd_ready, 1);
      check("t6_rel_done", pkt_done, 0);
      check("t6_rel_valid", TVALID, 0);
      set_ready_all(1'b1);
      send_cmd(16'd1, 32'h200, 3'd3, 4'd0, 4'h6, 4'h9);
      run(4);
      check("t6_data0", cyc_data[0], 32'h200);
      check("t6_user0", cyc_user[0], 1);
      check("t6_last0", cyc_last[0], 0);
      check("t6_data1", cyc_data[1], 32'h201);
      check("t6_last1", cyc_last[1], 1);
      check("t6_keep1", cyc_keep[1], 4'h7);
      check("t6_id", cyc_id[1], 8'h69);
      check("t6_done", cyc_done[2], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
